// File: rtl/reg_wb_pkg.sv
// Shared types for the register-file write-back controller: ISR-save FSM states,
// write-port source select, and default ISR save targets.
package reg_wb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSavePc,
        StSaveRand,
        StWaitRel
    } wb_state_e;

    typedef enum logic [1:0] {
        SrcNone,
        SrcFsm,
        SrcAlu,
        SrcLq
    } wb_src_e;

    localparam int unsigned PcRegDefault   = 30;
    localparam int unsigned RandRegDefault = 31;

    // States in which the FSM owns the write port and upstream must stall.
    function automatic logic is_save_state(input wb_state_e state);
        return (state == StSavePc) || (state == StSaveRand);
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small synchronous FIFO buffering load results ({rd, data}) until the write port is free.
// Depth must be a power of two so the pointers wrap naturally.
module wb_load_fifo #(
    parameter int unsigned Width = 37,
    parameter int unsigned Depth = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned        PtrW      = $clog2(Depth);
    localparam logic [PtrW-1:0]    PtrOne    = PtrW'(1);
    localparam logic [PtrW:0]      CntOne    = (PtrW + 1)'(1);
    localparam logic [PtrW:0]      FullCount = (PtrW + 1)'(Depth);

    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic [Width-1:0] mem_q [Depth];
    logic             push_ok, pop_ok;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrOne;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the count qualifies every entry.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-side master for the register file: arbitrates ISR context save, ALU results and
// buffered load results onto the single registered write port.
module reg_writeback_ctrl
    import reg_wb_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned LqDepth   = 2,
    parameter int unsigned PcReg     = PcRegDefault,
    parameter int unsigned RandReg   = RandRegDefault
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [DataWidth-1:0] alu_data,
    input  logic [AddrWidth-1:0] alu_rd,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [DataWidth-1:0] mem_data,
    input  logic [AddrWidth-1:0] mem_rd,
    input  logic                 int_req,
    input  logic [DataWidth-1:0] int_pc,
    input  logic [DataWidth-1:0] rand_in,
    output logic                 int_ack,
    output logic                 stall,
    output logic [DataWidth-1:0] wb_data,
    output logic [AddrWidth-1:0] wb_addr,
    output logic                 wb_write_en,
    output logic                 err
);

    wb_state_e            state_q;
    logic                 stall_q, int_ack_q, err_q;
    logic [DataWidth-1:0] pc_q, rand_q;
    logic [DataWidth-1:0] wb_data_q;
    logic [AddrWidth-1:0] wb_addr_q;
    logic                 wb_write_en_q;

    wb_src_e              sel;
    logic [DataWidth-1:0] sel_data;
    logic [AddrWidth-1:0] sel_addr;

    logic                 lq_full, lq_empty, lq_push, lq_pop;
    logic [DataWidth-1:0] lq_head_data;
    logic [AddrWidth-1:0] lq_head_rd;

    assign mem_ready = !lq_full;
    assign lq_push   = mem_valid && !lq_full;
    assign lq_pop    = (sel == SrcLq);

    wb_load_fifo #(
        .Width(DataWidth + AddrWidth),
        .Depth(LqDepth)
    ) u_load_fifo (
        .clk  (clk),
        .reset(reset),
        .push (lq_push),
        .pop  (lq_pop),
        .wdata({mem_rd, mem_data}),
        .rdata({lq_head_rd, lq_head_data}),
        .full (lq_full),
        .empty(lq_empty)
    );

    // Priority: ISR save > ALU > load queue head.
    always_comb begin
        sel      = SrcNone;
        sel_data = '0;
        sel_addr = '0;
        if (is_save_state(state_q)) begin
            sel = SrcFsm;
            if (state_q == StSavePc) begin
                sel_data = pc_q;
                sel_addr = AddrWidth'(PcReg);
            end else begin
                sel_data = rand_q;
                sel_addr = AddrWidth'(RandReg);
            end
        end else if (alu_valid) begin
            sel      = SrcAlu;
            sel_data = alu_data;
            sel_addr = alu_rd;
        end else if (!lq_empty) begin
            sel      = SrcLq;
            sel_data = lq_head_data;
            sel_addr = lq_head_rd;
        end
    end

    // stall_q and int_ack_q are updated on state transitions so they track the state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            stall_q   <= 1'b0;
            int_ack_q <= 1'b0;
            pc_q      <= '0;
            rand_q    <= '0;
        end else begin
            int_ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (int_req) begin
                        pc_q    <= int_pc;
                        rand_q  <= rand_in;
                        stall_q <= 1'b1;
                        state_q <= StSavePc;
                    end
                end
                StSavePc: begin
                    int_ack_q <= 1'b1;
                    state_q   <= StSaveRand;
                end
                StSaveRand: begin
                    stall_q <= 1'b0;
                    state_q <= StWaitRel;
                end
                StWaitRel: begin
                    if (!int_req) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Writes to R0 are consumed but never enabled; an idle port holds data/address.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data_q     <= '0;
            wb_addr_q     <= '0;
            wb_write_en_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            wb_write_en_q <= (sel != SrcNone) && (sel_addr != '0);
            if (sel != SrcNone) begin
                wb_data_q <= sel_data;
                wb_addr_q <= sel_addr;
            end
            err_q <= err_q | (alu_valid & stall_q);
        end
    end

    assign stall       = stall_q;
    assign int_ack     = int_ack_q;
    assign wb_data     = wb_data_q;
    assign wb_addr     = wb_addr_q;
    assign wb_write_en = wb_write_en_q;
    assign err         = err_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: ALU path, R0 suppression, load queue backpressure,
// ISR context save, stall violation and reset abandonment.
module tb_reg_writeback_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [31:0] alu_data;
    logic [4:0]  alu_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [4:0]  mem_rd;
    logic        int_req;
    logic [31:0] int_pc;
    logic [31:0] rand_in;
    logic        int_ack;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_write_en;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_writeback_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_data   (alu_data),
        .alu_rd     (alu_rd),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .mem_rd     (mem_rd),
        .int_req    (int_req),
        .int_pc     (int_pc),
        .rand_in    (rand_in),
        .int_ack    (int_ack),
        .stall      (stall),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr),
        .wb_write_en(wb_write_en),
        .err        (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        check_eq({tag, ".we"}, 32'(wb_write_en), 32'(we));
        if (we) begin
            check_eq({tag, ".addr"}, 32'(wb_addr), 32'(addr));
            check_eq({tag, ".data"}, wb_data, data);
        end
    endtask

    initial begin
        reset     = 1'b1;
        alu_valid = 1'b0;
        alu_data  = '0;
        alu_rd    = '0;
        mem_valid = 1'b0;
        mem_data  = '0;
        mem_rd    = '0;
        int_req   = 1'b0;
        int_pc    = '0;
        rand_in   = '0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst.we", 32'(wb_write_en), 32'd0);
        check_eq("rst.data", wb_data, 32'd0);
        check_eq("rst.addr", 32'(wb_addr), 32'd0);
        check_eq("rst.int_ack", 32'(int_ack), 32'd0);
        check_eq("rst.stall", 32'(stall), 32'd0);
        check_eq("rst.err", 32'(err), 32'd0);
        check_eq("rst.mem_ready", 32'(mem_ready), 32'd1);

        // 1: single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 1'b0;
        check_wb("alu1", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check_eq("alu1.idle_we", 32'(wb_write_en), 32'd0);
        check_eq("alu1.hold_data", wb_data, 32'hDEADBEEF);

        // 2: writes to R0 are suppressed, R0 load still popped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
        tick();
        alu_valid = 1'b0;
        check_eq("r0alu.we", 32'(wb_write_en), 32'd0);
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h55;
        tick();
        mem_valid = 1'b0;
        check_eq("r0ld.we0", 32'(wb_write_en), 32'd0);
        tick();
        check_eq("r0ld.we1", 32'(wb_write_en), 32'd0);
        check_eq("r0ld.ready", 32'(mem_ready), 32'd1);

        // 3: loads queue behind ALU stream, then drain in order
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA;
        tick();
        check_eq("lq.ready_1", 32'(mem_ready), 32'd1);
        mem_rd = 5'd11; mem_data = 32'hB;
        tick();
        check_eq("lq.ready_2", 32'(mem_ready), 32'd0);
        mem_rd = 5'd12; mem_data = 32'hC;
        tick();
        check_eq("lq.ready_full", 32'(mem_ready), 32'd0);
        check_wb("lq.alu", 1'b1, 5'd9, 32'h99);
        alu_valid = 1'b0;
        tick();
        check_wb("lq.load_a", 1'b1, 5'd10, 32'hA);
        check_eq("lq.ready_after_pop", 32'(mem_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
        check_wb("lq.load_b", 1'b1, 5'd11, 32'hB);
        tick();
        check_wb("lq.load_c", 1'b1, 5'd12, 32'hC);
        tick();
        check_eq("lq.drained_we", 32'(wb_write_en), 32'd0);
        check_eq("lq.drained_ready", 32'(mem_ready), 32'd1);

        // 4: ISR entry with a same-cycle ALU write
        int_req = 1'b1; int_pc = 32'h100; rand_in = 32'hA5A5A5A5;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick();
        alu_valid = 1'b0;
        check_wb("isr.alu", 1'b1, 5'd7, 32'h77);
        check_eq("isr.stall_1", 32'(stall), 32'd1);
        check_eq("isr.ack_1", 32'(int_ack), 32'd0);
        tick();
        check_wb("isr.pc", 1'b1, 5'd30, 32'h100);
        check_eq("isr.stall_2", 32'(stall), 32'd1);
        check_eq("isr.ack_2", 32'(int_ack), 32'd1);
        tick();
        check_wb("isr.rand", 1'b1, 5'd31, 32'hA5A5A5A5);
        check_eq("isr.stall_3", 32'(stall), 32'd0);
        check_eq("isr.ack_3", 32'(int_ack), 32'd0);
        tick();
        check_eq("isr.wait_we", 32'(wb_write_en), 32'd0);
        tick();
        check_eq("isr.no_retrigger_we", 32'(wb_write_en), 32'd0);
        check_eq("isr.no_retrigger_stall", 32'(stall), 32'd0);
        check_eq("isr.err", 32'(err), 32'd0);
        int_req = 1'b0;
        tick();

        // 5: ALU write during stall is dropped and sets sticky ERR
        int_req = 1'b1; int_pc = 32'h200; rand_in = 32'h3;
        tick();
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
        tick();
        alu_valid = 1'b0;
        check_wb("viol.pc", 1'b1, 5'd30, 32'h200);
        check_eq("viol.err_set", 32'(err), 32'd1);
        tick();
        check_wb("viol.rand", 1'b1, 5'd31, 32'h3);
        tick();
        check_eq("viol.no_alu_we", 32'(wb_write_en), 32'd0);
        check_eq("viol.no_alu_addr", 32'(wb_addr), 32'd31);
        int_req = 1'b0;
        tick();
        check_eq("viol.err_sticky", 32'(err), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("viol.err_cleared", 32'(err), 32'd0);

        // 6: reset in SAVE_PC with a load queued abandons everything
        int_req = 1'b1; int_pc = 32'h300; rand_in = 32'h4;
        mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'hD;
        tick();
        mem_valid = 1'b0; int_req = 1'b0;
        check_eq("mid.stall", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid.we", 32'(wb_write_en), 32'd0);
        check_eq("mid.addr", 32'(wb_addr), 32'd0);
        check_eq("mid.data", wb_data, 32'd0);
        check_eq("mid.stall_rst", 32'(stall), 32'd0);
        check_eq("mid.ack", 32'(int_ack), 32'd0);
        check_eq("mid.ready", 32'(mem_ready), 32'd1);
        tick();
        check_eq("mid.post_we_1", 32'(wb_write_en), 32'd0);
        tick();
        check_eq("mid.post_we_2", 32'(wb_write_en), 32'd0);
        check_eq("mid.post_stall", 32'(stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
